// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : round_sequencer
//  Purpose  : Round-index sequencer for the ASCON permutation constant stage.
//             A start request runs N rounds (N chosen by mode_i). Round
//             indices N_MAX-N .. N_MAX-1 are emitted one per clock, along
//             with the state-register enable and the first-round select.
//             A one-cycle done pulse follows the last round.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock_i     in   1  system clock, rising edge
//    reset_i     in   1  asynchronous active-high reset
//    start_i     in   1  permutation request, honoured in IDLE or DONE
//    mode_i      in   2  round-count select, latched with an accepted start
//    abort_i     in   1  synchronous abort, beats start_i
//    round_o     out  4  round index for the constant-addition stage
//    en_round_o  out  1  state register enable, high in every round cycle
//    sel_init_o  out  1  high in the first round cycle only
//    busy_o      out  1  high while rounds are running
//    done_o      out  1  one-cycle pulse after the last round
// ============================================================================
module round_sequencer #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int ROUNDS_C = 8,
  parameter int N_MAX    = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       abort_i,
  output logic [3:0] round_o,
  output logic       en_round_o,
  output logic       sel_init_o,
  output logic       busy_o,
  output logic       done_o
);

  // Refuse to build with a round count the constant table cannot serve.
  if (N_MAX < 1 || N_MAX > 16) begin : g_bad_n_max
    $error("round_sequencer: N_MAX must lie in 1..16");
  end
  if (ROUNDS_A < 1 || ROUNDS_A > N_MAX) begin : g_bad_rounds_a
    $error("round_sequencer: ROUNDS_A must lie in 1..N_MAX");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > N_MAX) begin : g_bad_rounds_b
    $error("round_sequencer: ROUNDS_B must lie in 1..N_MAX");
  end
  if (ROUNDS_C < 1 || ROUNDS_C > N_MAX) begin : g_bad_rounds_c
    $error("round_sequencer: ROUNDS_C must lie in 1..N_MAX");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Starting index for each mode; the count itself never needs storing
  // because every run ends at the same final index.
  localparam logic [3:0] c_first_a = 4'(N_MAX - ROUNDS_A);
  localparam logic [3:0] c_first_b = 4'(N_MAX - ROUNDS_B);
  localparam logic [3:0] c_first_c = 4'(N_MAX - ROUNDS_C);
  localparam logic [3:0] c_last    = 4'(N_MAX - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic       r_en;
  logic       w_en_nxt;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic [3:0] w_first;

  // Mode 2'b11 is reserved and falls back to the p^a count.
  always_comb begin
    w_first = c_first_a;
    case (mode_i)
      2'b01:   w_first = c_first_b;
      2'b10:   w_first = c_first_c;
      default: w_first = c_first_a;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_round <= 4'd0;
      r_en    <= 1'b0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_en    <= w_en_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output logic. The outputs are computed one cycle
  // ahead so that they line up with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_en_nxt    = 1'b0;
    w_sel_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    if (abort_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            w_state_nxt = RUN;
            w_round_nxt = w_first;
            w_en_nxt    = 1'b1;
            w_sel_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RUN: begin
          if (r_round == c_last) begin
            // Final round just ran; index stays parked at the last value.
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_en_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign round_o    = r_round;
  assign en_round_o = r_en;
  assign sel_init_o = r_sel;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_sequencer
//  Purpose  : Self-checking bench for round_sequencer. A reference model
//             expands each accepted request into its full list of expected
//             cycles (N round cycles followed by one done cycle) and plays
//             them back against the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_round_sequencer;

  logic       clk;
  logic       reset_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic       abort_i;
  logic [3:0] round_o;
  logic       en_round_o;
  logic       sel_init_o;
  logic       busy_o;
  logic       done_o;

  int vectors;
  int miscompares;

  round_sequencer dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .abort_i    (abort_i),
    .round_o    (round_o),
    .en_round_o (en_round_o),
    .sel_init_o (sel_init_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle: {round, en, sel, busy, done}.
  typedef struct packed {
    logic [3:0] r;
    logic       en;
    logic       sel;
    logic       busy;
    logic       done;
  } out_t;

  out_t q[$];
  out_t m_cur;

  logic [7:0] w_obs;
  assign w_obs = {round_o, en_round_o, sel_init_o, busy_o, done_o};

  function automatic int n_of(input logic [1:0] m);
    case (m)
      2'b01:   return 6;
      2'b10:   return 8;
      default: return 12;
    endcase
  endfunction

  // Model: a request is honoured whenever no round is currently running.
  task automatic model_edge(input logic s, input logic [1:0] md, input logic ab);
    int n;
    out_t e;
    if (ab) begin
      q.delete();
      m_cur = '{r: m_cur.r, default: 1'b0};
    end else if (s && !m_cur.busy) begin
      q.delete();
      n = n_of(md);
      for (int i = 0; i < n; i++) begin
        e = '{r: 4'(12 - n + i), en: 1'b1, sel: (i == 0), busy: 1'b1, done: 1'b0};
        q.push_back(e);
      end
      q.push_back('{r: 4'd11, en: 1'b0, sel: 1'b0, busy: 1'b0, done: 1'b1});
      m_cur = q.pop_front();
    end else if (q.size() > 0) begin
      m_cur = q.pop_front();
    end else begin
      m_cur = '{r: m_cur.r, default: 1'b0};
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cur = '0;
  endtask

  // Drive one cycle of inputs (from a negedge), advance the model at the
  // rising edge, and return at the next negedge ready to sample.
  task automatic cycle(input logic s, input logic [1:0] md, input logic ab);
    start_i = s;
    mode_i  = md;
    abort_i = ab;
    @(posedge clk);
    model_edge(s, md, ab);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 2'b00;
    abort_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (w_obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", w_obs, 8'h00);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'b00, 1'b0);
      vectors++;
      if (w_obs !== m_cur) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, w_obs, m_cur);
      end
    end
  endtask

  task automatic test_mode(input logic [1:0] md);
    int n;
    int done_at;
    int en_cnt;
    n = n_of(md);
    done_at = -1;
    cycle(1'b1, md, 1'b0);
    en_cnt = en_round_o ? 1 : 0;
    vectors++;
    if (w_obs !== m_cur) begin
      miscompares++;
      $display("FAIL mode%0d_first: got %h expected %h", md, w_obs, m_cur);
    end
    for (int i = 0; i < n + 3; i++) begin
      // Scramble mode mid-run: the latched count must not change.
      cycle(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      if (en_round_o) en_cnt++;
      if (done_o && done_at < 0) done_at = i + 2;
      vectors++;
      if (w_obs !== m_cur) begin
        miscompares++;
        $display("FAIL mode%0d_cycle[%0d]: got %h expected %h", md, i, w_obs, m_cur);
      end
    end
    vectors++;
    if (done_at != n + 1 || en_cnt != n) begin
      miscompares++;
      $display("FAIL mode%0d_latency: done at k+%0d en %0d, expected k+%0d en %0d",
               md, done_at, en_cnt, n + 1, n);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_done;
    int   restarts;
    prev_done = 1'b0;
    restarts  = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 2'b01, 1'b0);
      vectors++;
      if (w_obs !== m_cur) begin
        miscompares++;
        $display("FAIL b2b_cycle[%0d]: got %h expected %h", i, w_obs, m_cur);
      end
      if (prev_done) begin
        restarts++;
        vectors++;
        if (round_o !== 4'd6 || sel_init_o !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart[%0d]: got round %0d sel %b expected 6 1",
                   i, round_o, sel_init_o);
        end
      end
      prev_done = done_o;
    end
    vectors++;
    if (restarts < 2) begin
      miscompares++;
      $display("FAIL b2b_restart_count: got %0d expected at least 2", restarts);
    end
    cycle(1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_abort(input logic with_start);
    int guard;
    cycle(1'b1, 2'b00, 1'b0);
    guard = 0;
    while (round_o !== 4'd8 && guard < 20) begin
      cycle(1'b0, 2'b00, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 20) begin
      miscompares++;
      $display("FAIL abort_reach8: got round %0d expected 8 within 20 cycles", round_o);
    end
    cycle(with_start, 2'b01, 1'b1);
    vectors++;
    if (w_obs !== {4'd8, 4'b0000} || w_obs !== m_cur) begin
      miscompares++;
      $display("FAIL abort_next: got %h expected %h", w_obs, m_cur);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 2'b00, 1'b0);
      vectors++;
      if (w_obs !== m_cur || done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_after[%0d]: got %h expected %h", i, w_obs, m_cur);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int guard;
    cycle(1'b1, 2'b00, 1'b0);
    guard = 0;
    while (round_o !== 4'd8 && guard < 20) begin
      cycle(1'b0, 2'b00, 1'b0);
      guard++;
    end
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (w_obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", w_obs, 8'h00);
    end
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'b00, 1'b0);
      vectors++;
      if (w_obs !== m_cur) begin
        miscompares++;
        $display("FAIL reset_after[%0d]: got %h expected %h", i, w_obs, m_cur);
      end
    end
  endtask

  task automatic test_random();
    logic       s;
    logic       ab;
    logic [1:0] md;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 19) == 0);
      md = 2'($urandom_range(0, 3));
      cycle(s, md, ab);
      vectors++;
      if (w_obs !== m_cur) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, w_obs, m_cur);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mode(2'b00);
    test_mode(2'b01);
    test_mode(2'b10);
    test_mode(2'b11);
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
